// File: rtl/demux_event_counter.sv
// -----------------------------------------------------------------------------
// demux_event_counter
//
// Purpose:
//   Registers the four demultiplexer output lines, counts rising edges on each
//   line in an independent saturating counter, serves counter values through
//   a one-deep request/response read port and raises a sticky error flag when
//   more than one line is high in the same cycle.
//
// Ports:
//   clk        in   1      system clock, all state updates on rising edge
//   rst        in   1      synchronous active-high reset
//   ch_in      in   4      demux outputs, bit i = out i (synchronous to clk)
//   rd_req     in   1      read request strobe
//   rd_sel     in   2      channel index to read, sampled with rd_req
//   rd_data    out  CNT_W  counter value returned for the read
//   rd_valid   out  1      one-cycle pulse qualifying rd_data
//   multi_err  out  1      sticky multi-hot violation flag
//   err_clr    in   1      clears multi_err (a same-cycle violation wins)
//   ch_active  out  4      registered copy of ch_in
//
// Parameters:
//   CNT_W        width of each per-channel event counter
//   CLR_ON_READ  1: a read clears the addressed counter, 0: reads are
//                non-destructive
// -----------------------------------------------------------------------------
module demux_event_counter #(
    parameter int CNT_W       = 8,
    parameter bit CLR_ON_READ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ch_in,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             multi_err,
    input  logic             err_clr,
    output logic [3:0]       ch_active
);

    localparam logic [CNT_W-1:0] L_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] L_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_MAX  = {CNT_W{1'b1}};

    // Read path: IDLE, or RESP for the cycle after a request was captured.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_t;

    // True when more than one bit of the vector is set (clearing the lowest
    // set bit leaves something behind).
    function automatic logic f_multi_hot(input logic [3:0] v);
        return ((v & (v - 4'd1)) != 4'd0);
    endfunction

    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic [3:0]       r_ch_active;
    logic [3:0]       r_hist;
    logic [3:0]       w_edge;
    logic [3:0]       w_clr;
    logic [CNT_W-1:0] r_cnt     [4];
    logic [CNT_W-1:0] w_cnt_nxt [4];
    logic [1:0]       r_rd_sel;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_multi_err;
    logic             w_multi_nxt;

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign multi_err = r_multi_err;
    assign ch_active = r_ch_active;

    // Rising edge on the registered copy of each line.
    assign w_edge = r_ch_active & ~r_hist;

    // Read-path next state: a request always (re)enters RESP, which lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rd_req) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rd_req) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read-path state register; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-channel counter next value. A clear that coincides with an edge on
    // the same channel lands at 1 so the event is not lost.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_clr[i]     = 1'b0;
            w_cnt_nxt[i] = r_cnt[i];
            if (CLR_ON_READ && (r_state == ST_RESP) && (r_rd_sel == i[1:0])) begin
                w_clr[i] = 1'b1;
            end else begin
                w_clr[i] = 1'b0;
            end
            if (w_clr[i]) begin
                if (w_edge[i]) begin
                    w_cnt_nxt[i] = L_ONE;
                end else begin
                    w_cnt_nxt[i] = L_ZERO;
                end
            end else if (w_edge[i] && (r_cnt[i] != L_MAX)) begin
                w_cnt_nxt[i] = r_cnt[i] + L_ONE;
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Sticky multi-hot flag: a violation takes priority over err_clr.
    always_comb begin
        w_multi_nxt = r_multi_err;
        if (f_multi_hot(r_ch_active)) begin
            w_multi_nxt = 1'b1;
        end else if (err_clr) begin
            w_multi_nxt = 1'b0;
        end else begin
            w_multi_nxt = r_multi_err;
        end
    end

    // Input registering, edge history, counters and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_active <= 4'b0000;
            r_hist      <= 4'b0000;
            r_multi_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= L_ZERO;
            end
        end else begin
            r_ch_active <= ch_in;
            r_hist      <= r_ch_active;
            r_multi_err <= w_multi_nxt;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Read capture and response: rd_data returns the counter as it stood
    // after the request edge and otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sel   <= 2'd0;
            r_rd_data  <= L_ZERO;
            r_rd_valid <= 1'b0;
        end else begin
            if (rd_req) begin
                r_rd_sel <= rd_sel;
            end else begin
                r_rd_sel <= r_rd_sel;
            end
            if (r_state == ST_RESP) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= r_cnt[r_rd_sel];
            end else begin
                r_rd_valid <= 1'b0;
                r_rd_data  <= r_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_demux_event_counter.sv
// -----------------------------------------------------------------------------
// tb_demux_event_counter
//
// Purpose: directed self-checking bench for demux_event_counter with the
// default parameters (CNT_W=8, CLR_ON_READ=1). Tests run in sequence and the
// counter contents carry over from one test to the next; the expected values
// below account for that.
// -----------------------------------------------------------------------------
module tb_demux_event_counter;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       ch_in;
    logic             rd_req;
    logic [1:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             multi_err;
    logic             err_clr;
    logic [3:0]       ch_active;

    int n_vec;
    int n_err;

    demux_event_counter #(
        .CNT_W       (CNT_W),
        .CLR_ON_READ (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_in     (ch_in),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .multi_err (multi_err),
        .err_clr   (err_clr),
        .ch_active (ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One pulse (one cycle high, one cycle low) on the lines in mask.
    task automatic pulse(input logic [3:0] mask, input int n);
        for (int k = 0; k < n; k++) begin
            ch_in = mask;
            step(1);
            ch_in = 4'b0000;
            step(1);
        end
    endtask

    // Single read: returns rd_valid/rd_data after the response edge and
    // rd_valid one edge later.
    task automatic do_read(input logic [1:0] sel, output logic [CNT_W-1:0] data,
                           output logic v1, output logic v2);
        rd_req = 1'b1;
        rd_sel = sel;
        step(1);
        rd_req = 1'b0;
        step(1);
        v1   = rd_valid;
        data = rd_data;
        step(1);
        v2 = rd_valid;
    endtask

    task automatic test_reset();
        logic [CNT_W-1:0] d;
        logic v1, v2;
        rst = 1'b1;
        ch_in = 4'b1111;
        step(2);
        n_vec++;
        if ({ch_active, rd_valid, rd_data, multi_err} !== {4'b0000, 1'b0, 8'd0, 1'b0}) begin
            $display("FAIL reset_outputs: ch_active=%b rd_valid=%b rd_data=%0d multi_err=%b, required 0000 0 0 0",
                     ch_active, rd_valid, rd_data, multi_err);
            n_err++;
        end
        rst = 1'b0;
        step(1);
        n_vec++;
        if (ch_active !== 4'b1111) begin
            $display("FAIL reset_release_ch_active: got %b, required 1111", ch_active);
            n_err++;
        end
        ch_in = 4'b0000;
        step(1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        n_vec++;
        if (multi_err !== 1'b0) begin
            $display("FAIL reset_err_clr: got %b, required 0", multi_err);
            n_err++;
        end
        for (int c = 0; c < 4; c++) begin
            do_read(c[1:0], d, v1, v2);
            n_vec++;
            if (v1 !== 1'b1 || d !== 8'd1) begin
                $display("FAIL reset_count_ch%0d: valid=%b data=%0d, required valid=1 data=1", c, v1, d);
                n_err++;
            end
        end
    endtask

    task automatic test_counting();
        logic [CNT_W-1:0] d;
        logic v1, v2;
        pulse(4'b0100, 5);
        step(2);
        do_read(2'd2, d, v1, v2);
        n_vec++;
        if (v1 !== 1'b1 || d !== 8'd5) begin
            $display("FAIL count_ch2: valid=%b data=%0d, required valid=1 data=5", v1, d);
            n_err++;
        end
        n_vec++;
        if (v2 !== 1'b0) begin
            $display("FAIL count_valid_one_cycle: rd_valid=%b, required 0", v2);
            n_err++;
        end
        do_read(2'd2, d, v1, v2);
        n_vec++;
        if (v1 !== 1'b1 || d !== 8'd0) begin
            $display("FAIL count_ch2_after_clear: valid=%b data=%0d, required valid=1 data=0", v1, d);
            n_err++;
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] d;
        logic v1, v2;
        pulse(4'b0001, 300);
        step(2);
        // Next pulse sampled on the same edge as the request: its increment
        // coincides with the clear.
        ch_in  = 4'b0001;
        rd_req = 1'b1;
        rd_sel = 2'd0;
        step(1);
        ch_in  = 4'b0000;
        rd_req = 1'b0;
        step(1);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 8'd255) begin
            $display("FAIL sat_ch0: valid=%b data=%0d, required valid=1 data=255", rd_valid, rd_data);
            n_err++;
        end
        step(2);
        do_read(2'd0, d, v1, v2);
        n_vec++;
        if (v1 !== 1'b1 || d !== 8'd1) begin
            $display("FAIL sat_clear_with_edge: valid=%b data=%0d, required valid=1 data=1", v1, d);
            n_err++;
        end
    endtask

    task automatic test_multi_hot();
        ch_in = 4'b0101;
        step(1);
        ch_in = 4'b0000;
        n_vec++;
        if (multi_err !== 1'b0) begin
            $display("FAIL multi_early: got %b, required 0 one edge after violation", multi_err);
            n_err++;
        end
        step(1);
        n_vec++;
        if (multi_err !== 1'b1) begin
            $display("FAIL multi_set: got %b, required 1", multi_err);
            n_err++;
        end
        step(3);
        n_vec++;
        if (multi_err !== 1'b1) begin
            $display("FAIL multi_sticky: got %b, required 1", multi_err);
            n_err++;
        end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        n_vec++;
        if (multi_err !== 1'b0) begin
            $display("FAIL multi_clear: got %b, required 0", multi_err);
            n_err++;
        end
        ch_in = 4'b0011;
        step(2);
        err_clr = 1'b1;
        step(1);
        n_vec++;
        if (multi_err !== 1'b1) begin
            $display("FAIL multi_clear_vs_violation: got %b, required 1", multi_err);
            n_err++;
        end
        ch_in = 4'b0000;
        step(2);
        err_clr = 1'b0;
        n_vec++;
        if (multi_err !== 1'b0) begin
            $display("FAIL multi_final_clear: got %b, required 0", multi_err);
            n_err++;
        end
    endtask

    // Carried counts entering this test: ch0=2, ch1=1, ch2=1, ch3=0.
    task automatic test_back_to_back();
        logic [CNT_W-1:0] exp_cnt [4];
        logic [CNT_W-1:0] d;
        logic v1, v2;
        exp_cnt[0] = 8'd2;
        exp_cnt[1] = 8'd1;
        exp_cnt[2] = 8'd3;
        exp_cnt[3] = 8'd3;
        pulse(4'b1000, 3);
        pulse(4'b0100, 2);
        step(2);
        rd_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                rd_sel = c[1:0];
            end else begin
                rd_req = 1'b0;
            end
            step(1);
            if (c > 0) begin
                n_vec++;
                if (rd_valid !== 1'b1 || rd_data !== exp_cnt[c-1]) begin
                    $display("FAIL b2b_ch%0d: valid=%b data=%0d, required valid=1 data=%0d",
                             c - 1, rd_valid, rd_data, exp_cnt[c-1]);
                    n_err++;
                end
            end
        end
        step(1);
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 8'd3) begin
            $display("FAIL b2b_hold: valid=%b data=%0d, required valid=0 data=3", rd_valid, rd_data);
            n_err++;
        end
        // Same channel twice in a row: second read sees the cleared counter.
        pulse(4'b0010, 1);
        step(2);
        rd_req = 1'b1;
        rd_sel = 2'd1;
        step(2);
        v1 = rd_valid;
        d  = rd_data;
        rd_req = 1'b0;
        step(1);
        n_vec++;
        if (v1 !== 1'b1 || d !== 8'd1 || rd_valid !== 1'b1 || rd_data !== 8'd0) begin
            $display("FAIL b2b_same_ch: first valid=%b data=%0d second valid=%b data=%0d, required 1/1 then 1/0",
                     v1, d, rd_valid, rd_data);
            n_err++;
        end
        step(1);
    endtask

    task automatic test_reset_mid_read();
        logic [CNT_W-1:0] d;
        logic v1, v2;
        pulse(4'b1000, 2);
        step(2);
        rd_req = 1'b1;
        rd_sel = 2'd3;
        step(1);
        rd_req = 1'b0;
        rst    = 1'b1;
        step(1);
        rst = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 8'd0) begin
            $display("FAIL rst_mid_read: valid=%b data=%0d, required valid=0 data=0", rd_valid, rd_data);
            n_err++;
        end
        step(1);
        n_vec++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL rst_mid_read_late: valid=%b, required 0", rd_valid);
            n_err++;
        end
        do_read(2'd3, d, v1, v2);
        n_vec++;
        if (v1 !== 1'b1 || d !== 8'd0) begin
            $display("FAIL rst_mid_read_cnt: valid=%b data=%0d, required valid=1 data=0", v1, d);
            n_err++;
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        ch_in   = 4'b0000;
        rd_req  = 1'b0;
        rd_sel  = 2'd0;
        err_clr = 1'b0;
        #1;
        test_reset();
        test_counting();
        test_saturation();
        test_multi_hot();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
